// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, two write ports, issue/scoreboard and bulk-clear control.
// Master drives addresses/writes/issue/clear; slave returns read data, busy bits and clear status.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wen0;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic            wen1;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            clr_req;
    logic            clr_busy;

    modport master (
        output rs1, rs2, wen0, wa0, wd0, wen1, wa1, wd1, issue_valid, issue_rd, clr_req,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, clr_busy
    );

    modport slave (
        input  rs1, rs2, wen0, wa0, wd0, wen1, wa1, wd1, issue_valid, issue_rd, clr_req,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, clr_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Dual-write register file with busy scoreboard and sequential bulk clear; RF_BYPASS_EN adds write forwarding.
// Latency: reads combinational, writes/busy visible next cycle; bulk clear runs NREGS-1 cycles.
// Backpressure: none; while clr_busy is high writes, issues and clear requests are dropped.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     cnt;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  busy, busy_nxt;
    logic              clr_start, clr_last, idle;
    logic              we0, we1;

    assign idle = (state == IDLE);
    assign we0  = idle && bus.wen0 && (bus.wa0 != '0);
    assign we1  = idle && bus.wen1 && (bus.wa1 != '0);

    always_comb begin
        state_nxt = state;
        clr_start = 1'b0;
        clr_last  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt = CLEAR;
                    clr_start = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    clr_last  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (clr_start)
                cnt <= AW'(1);
            else if (state == CLEAR)
                cnt <= clr_last ? '0 : cnt + AW'(1);
        end
    end

    // Port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else begin
            if (we0)
                regs[bus.wa0] <= bus.wd0;
            if (we1)
                regs[bus.wa1] <= bus.wd1;
        end
    end

    // Issue is applied after the write-clears: the issued instruction is younger.
    always_comb begin
        busy_nxt = busy;
        if (idle) begin
            if (bus.clr_req) begin
                busy_nxt = '0;
            end else begin
                if (we0)
                    busy_nxt[bus.wa0] = 1'b0;
                if (we1)
                    busy_nxt[bus.wa1] = 1'b0;
                if (bus.issue_valid)
                    busy_nxt[bus.issue_rd] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign bus.clr_busy = (state == CLEAR);

`ifdef RF_BYPASS_EN
    logic f1_1, f1_0, f2_1, f2_0;

    // we0/we1 already exclude address 0 and the CLEAR state.
    assign f1_1 = we1 && (bus.wa1 == bus.rs1);
    assign f1_0 = we0 && (bus.wa0 == bus.rs1);
    assign f2_1 = we1 && (bus.wa1 == bus.rs2);
    assign f2_0 = we0 && (bus.wa0 == bus.rs2);

    assign bus.rs1_data = f1_1 ? bus.wd1 : f1_0 ? bus.wd0 : regs[bus.rs1];
    assign bus.rs2_data = f2_1 ? bus.wd1 : f2_0 ? bus.wd0 : regs[bus.rs2];
    assign bus.rs1_busy = (f1_1 || f1_0) ? 1'b0 : busy[bus.rs1];
    assign bus.rs2_busy = (f2_1 || f2_0) ? 1'b0 : busy[bus.rs2];
`else
    assign bus.rs1_data = regs[bus.rs1];
    assign bus.rs2_data = regs[bus.rs2];
    assign bus.rs1_busy = busy[bus.rs1];
    assign bus.rs2_busy = busy[bus.rs2];
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: vector table for read/write/scoreboard/bypass, hand sequences for bulk clear.
module tb_regfile_sb;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    regfile_sb_if bus ();
    regfile_sb dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        wen0; logic [4:0] wa0; logic [31:0] wd0;
        logic        wen1; logic [4:0] wa1; logic [31:0] wd1;
        logic        iv;   logic [4:0] ird;
        logic [4:0]  rs1;  logic [4:0] rs2;
        logic [31:0] e1;   logic [31:0] e2;
        logic        b1;   logic       b2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic w0, logic [4:0] a0, logic [31:0] d0,
                                logic w1, logic [4:0] a1, logic [31:0] d1,
                                logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2,
                                logic [31:0] e1, logic [31:0] e2, logic b1, logic b2);
        vec_t v;
        v.wen0 = w0; v.wa0 = a0; v.wd0 = d0;
        v.wen1 = w1; v.wa1 = a1; v.wd1 = d1;
        v.iv = iv; v.ird = ird; v.rs1 = r1; v.rs2 = r2;
        v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wen0 = 0; bus.wa0 = 0; bus.wd0 = 0;
        bus.wen1 = 0; bus.wa1 = 0; bus.wd1 = 0;
        bus.issue_valid = 0; bus.issue_rd = 0; bus.clr_req = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.wen0 = 1; bus.wa0 = a; bus.wd0 = d;
        @(posedge clk); #1;
        bus.wen0 = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        idle_inputs();
        bus.rs1 = 0; bus.rs2 = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 chk("clr_busy in reset", {31'd0, bus.clr_busy}, 0);
        @(negedge clk) reset = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus.rs1 = 5'(a); bus.rs2 = 5'(31 - a);
            #1;
            chk($sformatf("reset rs1_data[%0d]", a), bus.rs1_data, 0);
            chk($sformatf("reset rs2_data[%0d]", 31 - a), bus.rs2_data, 0);
            chk("reset rs1_busy", {31'd0, bus.rs1_busy}, 0);
            chk("reset rs2_busy", {31'd0, bus.rs2_busy}, 0);
        end
        chk("reset clr_busy", {31'd0, bus.clr_busy}, 0);

        //               w0 a0  d0            w1 a1  d1            iv ird rs1 rs2 e1 e2 b1 b2
        tbl.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  0,  1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 5,  32'h11111111, 1, 6,  32'h22222222, 0, 0,  2,  3,  0, 0, 0, 0));
        tbl.push_back(mk(1, 7,  32'h33333333, 1, 7,  32'h22222222, 0, 0,  5,  6,
                         32'h11111111, 32'h22222222, 0, 0));
        tbl.push_back(mk(1, 0,  32'hDEADBEEF, 0, 0,  0,            1, 0,  7,  0,  32'h22222222, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  0,  0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,  0,            1, 9,  0,  7,  0, 32'h22222222, 0, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  9,  0,  0, 0, 1, 0));
        tbl.push_back(mk(0, 0,  0,            1, 9,  32'h99,       0, 0,  0,  5,  0, 32'h11111111, 0, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  9,  9,  32'h99, 32'h99, 0, 0));
        tbl.push_back(mk(1, 9,  32'h9A,       0, 0,  0,            1, 9,  1,  2,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  9,  7,  32'h9A, 32'h22222222, 1, 0));
        tbl.push_back(mk(1, 12, 32'hA5A5A5A5, 0, 0,  0,            0, 0,  9,  12,
                         32'h9A, BYP ? 32'hA5A5A5A5 : 32'h0, 1, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  12, 12,
                         32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,  0,            1, 13, 0,  0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 13, 32'h1313,     1, 13, 13, 13,
                         BYP ? 32'h1313 : 32'h0, BYP ? 32'h1313 : 32'h0, !BYP, !BYP));
        tbl.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  13, 0,  32'h1313, 0, 1, 0));
        tbl.push_back(mk(1, 14, 32'hAAAA,     1, 14, 32'hBBBB,     0, 0,  14, 15,
                         BYP ? 32'hBBBB : 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  14, 14, 32'hBBBB, 32'hBBBB, 0, 0));

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            bus.wen0 = tbl[i].wen0; bus.wa0 = tbl[i].wa0; bus.wd0 = tbl[i].wd0;
            bus.wen1 = tbl[i].wen1; bus.wa1 = tbl[i].wa1; bus.wd1 = tbl[i].wd1;
            bus.issue_valid = tbl[i].iv; bus.issue_rd = tbl[i].ird;
            bus.rs1 = tbl[i].rs1; bus.rs2 = tbl[i].rs2;
            #2;
            chk($sformatf("row%0d rs1_data", i), bus.rs1_data, tbl[i].e1);
            chk($sformatf("row%0d rs2_data", i), bus.rs2_data, tbl[i].e2);
            chk($sformatf("row%0d rs1_busy", i), {31'd0, bus.rs1_busy}, {31'd0, tbl[i].b1});
            chk($sformatf("row%0d rs2_busy", i), {31'd0, bus.rs2_busy}, {31'd0, tbl[i].b2});
            chk($sformatf("row%0d clr_busy", i), {31'd0, bus.clr_busy}, 0);
        end
        @(posedge clk); #1 idle_inputs();

        // Bulk clear: fill, mark reg 3 busy, then clear
        for (int a = 1; a < 32; a++) wr(5'(a), 32'(a));
        bus.issue_valid = 1; bus.issue_rd = 3;
        @(posedge clk); #1 bus.issue_valid = 0;
        bus.rs1 = 3; #1;
        chk("pre-clear busy[3]", {31'd0, bus.rs1_busy}, 1);
        bus.clr_req = 1;
        @(posedge clk); #1 bus.clr_req = 0;
        cnt = 0;
        while (bus.clr_busy && cnt < 100) begin
            cnt++;
            if (cnt == 1) begin
                bus.rs1 = 3; #1;
                chk("clear busy[3] cleared", {31'd0, bus.rs1_busy}, 0);
            end
            if (cnt == 3) begin
                bus.rs1 = 5; bus.rs2 = 1; #1;
                chk("mid-clear reg5 live", bus.rs1_data, 5);
                chk("mid-clear reg1 zeroed", bus.rs2_data, 0);
            end
            if (cnt == 10) begin
                bus.wen0 = 1; bus.wa0 = 4; bus.wd0 = 32'hFFFF;
                bus.issue_valid = 1; bus.issue_rd = 20;
            end
            if (cnt == 11) idle_inputs();
            if (cnt == 12) bus.clr_req = 1;
            if (cnt == 13) bus.clr_req = 0;
            @(posedge clk); #1;
        end
        chk("clr_busy cycles", cnt, 31);
        for (int a = 0; a < 32; a++) begin
            bus.rs1 = 5'(a); bus.rs2 = 5'(a); #1;
            chk($sformatf("post-clear reg%0d", a), bus.rs1_data, 0);
            chk($sformatf("post-clear busy%0d", a), {31'd0, bus.rs2_busy}, 0);
        end

        // Reset during a clear aborts it immediately
        wr(20, 32'h20);
        bus.clr_req = 1;
        @(posedge clk); #1 bus.clr_req = 0;
        cnt = 0;
        while (bus.clr_busy && cnt < 10) begin
            cnt++;
            if (cnt < 10) begin
                @(posedge clk); #1;
            end
        end
        chk("clear running at cycle 10", {31'd0, bus.clr_busy}, 1);
        reset = 1'b0;
        bus.rs1 = 20; #1;
        chk("reset aborts clear", {31'd0, bus.clr_busy}, 0);
        chk("reset zeroes reg20", bus.rs1_data, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("clr_busy after reset release", {31'd0, bus.clr_busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the core's single-write register file.
- Adds a second write port for the ALU and load-return paths.
- Adds a per-register busy scoreboard for hazard detection.
- Adds a sequential bulk-clear engine.
- Sits in decode/writeback. Register 0 is hard-wired to zero.

Parameters:
XLEN, 32, data width of each register in bits
NREGS, 32, number of architectural registers; power of two, at least 4
AW, $clog2(NREGS), address width (localparam, derived, not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
rs1  input  AW  read address, port 1
rs2  input  AW  read address, port 2
rs1_data  output  XLEN  read data, port 1 (combinational)
rs2_data  output  XLEN  read data, port 2 (combinational)
wen0  input  1  write enable, port 0 (ALU writeback)
wa0  input  AW  write address, port 0
wd0  input  XLEN  write data, port 0
wen1  input  1  write enable, port 1 (load return)
wa1  input  AW  write address, port 1
wd1  input  XLEN  write data, port 1
issue_valid  input  1  instruction issued this cycle; marks issue_rd busy
issue_rd  input  AW  destination register of the issued instruction
rs1_busy  output  1  busy bit of rs1 (combinational)
rs2_busy  output  1  busy bit of rs2 (combinational)
clr_req  input  1  request a bulk clear (single-cycle pulse)
clr_busy  output  1  bulk clear in progress

Behaviour:
- Reset (reset = 0, asynchronous):
  - All registers = 0, all busy bits = 0, FSM = IDLE, clear counter = 0.
  - Outputs: rs*_data = 0, rs*_busy = 0, clr_busy = 0.
  - Reset asserted mid-clear aborts the clear immediately.
- Reads: rs1_data = reg[rs1], rs2_data = reg[rs2], combinational. Address 0 always reads 0.
- Writes:
  - Take effect on the rising clk edge; visible on reads from the next cycle.
  - Writes to address 0 are ignored.
  - wen0 and wen1 to the same nonzero address in one cycle: port 1 wins, port 0 data is dropped.
- Scoreboard:
  - busy[issue_rd] is set at the edge when issue_valid = 1 and issue_rd != 0.
  - busy[wa0] is cleared at the edge when wen0 = 1; busy[wa1] likewise for wen1.
  - Issue and write to the same register in the same cycle: set wins (the issue is younger).
  - busy[0] is always 0.
  - rs1_busy = busy[rs1], rs2_busy = busy[rs2].
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req = 1. On that edge, all busy bits are cleared and the counter is loaded with 1.
  - In CLEAR: reg[counter] is zeroed each edge and the counter increments. When counter = NREGS-1, that register is cleared and the FSM returns to IDLE. The clear takes NREGS-1 cycles.
  - clr_busy = 1 exactly while in CLEAR.
  - In CLEAR, wen0, wen1, issue_valid and clr_req are ignored. Reads remain live and return partially cleared contents.
  - clr_req while in CLEAR has no effect; the clear is not restarted.
- The counter is AW bits wide. No wrap occurs because the exit happens at NREGS-1.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: write-to-read forwarding is enabled.
  - If rsN matches an active nonzero write address this cycle, rsN_data returns that write's data; port 1 takes priority over port 0.
  - rsN_busy is forced to 0 when forwarding from a write to the same address. An issue to that same register in the same cycle does not change rsN_busy; it only takes effect next cycle.
  - No forwarding while clr_busy = 1.
- Undefined: reads return the stored value only, and new data appears one cycle after the write edge.

Test Plan:
- Reset: hold reset = 0, then release. Read all 32 addresses -> all 0; rs1_busy = rs2_busy = 0; clr_busy = 0.
- Dual write: wen0 wa0 = 5 wd0 = 0x1111_1111 together with wen1 wa1 = 6 wd1 = 0x2222_2222. Next cycle rs1 = 5, rs2 = 6 -> 0x11111111, 0x22222222. Repeat with wa0 = wa1 = 7 -> reg7 = 0x22222222.
- x0 protection: wen0 wa0 = 0 wd0 = 0xDEAD_BEEF and issue_rd = 0 -> rs1 = 0 reads 0, rs1_busy = 0.
- Scoreboard: issue_rd = 9 -> next cycle rs1_busy = 1 at rs1 = 9. wen1 wa1 = 9 -> next cycle busy = 0. Same-cycle issue_rd = 9 with wen0 wa0 = 9 -> busy stays 1.
- Bulk clear: fill regs 1..31 with index values, busy on reg 3, pulse clr_req. Required response:
  - clr_busy high for exactly 31 cycles.
  - busy[3] = 0 from the first clear edge.
  - A wen0 to reg 4 mid-clear is dropped.
  - Afterwards all regs read 0.
  - reset = 0 at cycle 10 of the clear -> clr_busy = 0 immediately.
- Bypass: wen0 wa0 = 12 wd0 = 0xA5A5_A5A5 with rs2 = 12 in the same cycle. With RF_BYPASS_EN -> rs2_data = 0xA5A5A5A5 that cycle. Without -> old value, then 0xA5A5A5A5 next cycle.
